cpu_hazard_scoreboard: RTL and testbench
========================================

CPU_HAZARD_SCOREBOARD -- requirements
Module: cpu_hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 16, number of architectural registers; RW = $clog2(NUM_REGS).
REQ-002 Parameter WDOG_CYCLES, default 64, consecutive-stall limit before watchdog error.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port decode_ra, decode_rb  input  RW each  decode source register indices.
REQ-006 Port ra_use, rb_use  input  1 each  the corresponding source is read by the decode instruction.
REQ-007 Port branch_decode, jump_decode  input  1 each  the decode instruction is a branch or register jump resolved in decode.
REQ-008 Port issue_valid  input  1  the execute stage holds a real instruction, not a bubble.
REQ-009 Port execute_rd  input  RW  execute-stage destination register.
REQ-010 Port execute_wb, execute_mem_read  input  1 each  execute instruction writes rd; it is a load.
REQ-011 Port wb_valid, wb_rd  input  1, RW  load data written back to wb_rd this cycle.
REQ-012 Port flush  input  1  kills the execute-stage instruction this cycle.
REQ-013 Port stall  output  1  freeze fetch and decode, inject bubble into execute.
REQ-014 Port stall_cause  output  2  00 none, 01 load-use, 10 branch/jump operand.
REQ-015 Port pending  output  NUM_REGS  scoreboard bit vector.
REQ-016 Port wdog_err  output  1  sticky watchdog error.

Function
REQ-017 Scoreboard SHALL set pending[execute_rd] on each cycle where issue_valid & execute_mem_read & execute_wb & !flush & execute_rd!=0.
REQ-018 Scoreboard SHALL clear pending[wb_rd] on wb_valid; a set and a clear to the same register in one cycle leave it set.
REQ-019 pending[0] SHALL always read 0.
REQ-020 Load-use hazard: (ra_use & pending[decode_ra]) | (rb_use & pending[decode_rb]), with register 0 excluded.
REQ-021 Branch hazard: (branch_decode|jump_decode) & issue_valid & execute_wb & !flush & execute_rd!=0, where execute_rd matches a used source.
REQ-022 stall SHALL be combinational, with zero-cycle latency, and equal to load-use OR branch hazard; stall_cause SHALL be 01 when load-use holds, else 10 when branch holds, else 00.
REQ-023 FSM states are RUN and STALLED; RUN->STALLED when stall=1; STALLED->RUN when stall=0; the transition is evaluated every cycle.
REQ-024 A consecutive-stall counter SHALL increment in STALLED while stall=1 and SHALL clear in RUN; on reaching WDOG_CYCLES it SHALL set wdog_err, which holds until reset. The counter saturates.
REQ-025 flush SHALL not clear scoreboard bits of loads already recorded.

Reset
REQ-026 While rst_n=0: pending=0, FSM=RUN, counters=0, wdog_err=0, stall=0, stall_cause=00, regardless of inputs.
REQ-027 Reset asserted mid-stall SHALL drop stall within the same cycle; after release, stall SHALL reflect only the inputs, with an empty scoreboard.

Configuration
REQ-028 Macro CPU_HDU_STATS_EN defined: adds output stall_count[31:0], which increments on each clk edge with stall=1, saturates at 0xFFFFFFFF and is reset to 0.
REQ-029 Macro CPU_HDU_STATS_EN undefined: no stall_count port and no counter logic; all other behaviour is identical.

Verification
REQ-030 Load to r3 issued with issue_valid=1; next cycle decode ra=3, ra_use=1 -> stall=1, cause=01; wb_valid, wb_rd=3 -> the following cycle stall=0 and pending[3]=0.
REQ-031 Load to r0 issued -> pending stays 0; decode reads r0 -> stall=0.
REQ-032 ALU write to r5 in execute; branch_decode with rb=5, rb_use=1 -> stall=1, cause=10 for exactly one cycle once execute becomes a bubble (issue_valid=0).
REQ-033 Load to r4 issued with flush=1 -> pending[4]=0; in the same cycle, wb_valid for r4 with a new load to r4 -> pending[4] remains 1.
REQ-034 Hold the load-use condition for 64 cycles -> wdog_err=1 on the 64th edge; then remove the hazard -> wdog_err stays 1 until rst_n pulse.
REQ-035 With CPU_HDU_STATS_EN: 10 stall cycles -> stall_count=10; rst_n low mid-sequence -> stall_count=0, stall=0 immediately.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// rtl/cpu_hazard_scoreboard.sv - load-use / branch-operand hazard scoreboard with stall watchdog
// Optional stall statistics counter enabled by defining CPU_HDU_STATS_EN.
module cpu_hazard_scoreboard #(
    parameter  int NUM_REGS    = 16,
    parameter  int WDOG_CYCLES = 64,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RW-1:0]       decode_ra,
    input  logic [RW-1:0]       decode_rb,
    input  logic                ra_use,
    input  logic                rb_use,
    input  logic                branch_decode,
    input  logic                jump_decode,
    input  logic                issue_valid,
    input  logic [RW-1:0]       execute_rd,
    input  logic                execute_wb,
    input  logic                execute_mem_read,
    input  logic                wb_valid,
    input  logic [RW-1:0]       wb_rd,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          stall_cause,
`ifdef CPU_HDU_STATS_EN
    output logic [31:0]         stall_count,
`endif
    output logic [NUM_REGS-1:0] pending,
    output logic                wdog_err
);

    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_MAX = CW'(WDOG_CYCLES);

    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CW-1:0]       wdog_cnt_q, wdog_cnt_d;
    logic                wdog_err_q, wdog_err_d;

    logic                ex_writes;
    logic                load_use;
    logic                branch_haz;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // A live, unflushed execute instruction that writes a non-zero register.
    assign ex_writes = issue_valid & execute_wb & ~flush & (execute_rd != '0);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ex_writes && execute_mem_read) begin
            set_vec[execute_rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_vec[wb_rd] = 1'b1;
        end
    end

    // Set wins over clear so a back-to-back load to the same register stays tracked.
    always_comb begin
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        load_use = 1'b0;
        if (ra_use && (decode_ra != '0) && pending_q[decode_ra]) begin
            load_use = 1'b1;
        end
        if (rb_use && (decode_rb != '0) && pending_q[decode_rb]) begin
            load_use = 1'b1;
        end
    end

    always_comb begin
        branch_haz = 1'b0;
        if ((branch_decode || jump_decode) && ex_writes) begin
            if ((ra_use && (decode_ra == execute_rd)) ||
                (rb_use && (decode_rb == execute_rd))) begin
                branch_haz = 1'b1;
            end
        end
    end

    // Gated by rst_n so an asserted reset drops stall without waiting for a clock.
    always_comb begin
        stall       = rst_n & (load_use | branch_haz);
        stall_cause = 2'b00;
        if (rst_n) begin
            if (load_use) begin
                stall_cause = 2'b01;
            end else if (branch_haz) begin
                stall_cause = 2'b10;
            end
        end
    end

    // The RUN-cycle stall edge counts as the first of a run, so the
    // WDOG_CYCLES-th consecutive stalled edge is the one that trips the error.
    always_comb begin
        state_d    = stall ? STALLED : RUN;
        wdog_cnt_d = '0;
        case (state_q)
            RUN: begin
                wdog_cnt_d = stall ? CW'(1) : '0;
            end
            STALLED: begin
                if (!stall) begin
                    wdog_cnt_d = '0;
                end else if (wdog_cnt_q >= WDOG_MAX) begin
                    wdog_cnt_d = WDOG_MAX;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + CW'(1);
                end
            end
            default: begin
                wdog_cnt_d = '0;
            end
        endcase
        wdog_err_d = wdog_err_q | (stall & (wdog_cnt_d >= WDOG_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pending_q  <= '0;
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign pending  = pending_q;
    assign wdog_err = wdog_err_q;

`ifdef CPU_HDU_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// tb/tb_cpu_hazard_scoreboard.sv - randomized and directed bench for cpu_hazard_scoreboard
module tb_cpu_hazard_scoreboard;

    localparam int NR = 16;
    localparam int RW = 4;
    localparam int WD = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] decode_ra, decode_rb, execute_rd, wb_rd;
    logic          ra_use, rb_use, branch_decode, jump_decode;
    logic          issue_valid, execute_wb, execute_mem_read, wb_valid, flush;
    logic          stall;
    logic [1:0]    stall_cause;
    logic [NR-1:0] pending;
    logic          wdog_err;
`ifdef CPU_HDU_STATS_EN
    logic [31:0]   stall_count;
`endif

    cpu_hazard_scoreboard #(.NUM_REGS(NR), .WDOG_CYCLES(WD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .decode_ra        (decode_ra),
        .decode_rb        (decode_rb),
        .ra_use           (ra_use),
        .rb_use           (rb_use),
        .branch_decode    (branch_decode),
        .jump_decode      (jump_decode),
        .issue_valid      (issue_valid),
        .execute_rd       (execute_rd),
        .execute_wb       (execute_wb),
        .execute_mem_read (execute_mem_read),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .flush            (flush),
        .stall            (stall),
        .stall_cause      (stall_cause),
`ifdef CPU_HDU_STATS_EN
        .stall_count      (stall_count),
`endif
        .pending          (pending),
        .wdog_err         (wdog_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: per-register "load outstanding" flags, length of the
    // current run of stalled cycles, sticky watchdog flag, total stalls.
    bit          mpend [NR];
    int          run_len;
    bit          mwdog;
    longint      mcount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mvec();
        logic [31:0] v = '0;
        for (int i = 1; i < NR; i++) v[i] = mpend[i];
        return v;
    endfunction

    function automatic bit m_load_use();
        return (ra_use && decode_ra != 0 && mpend[decode_ra]) ||
               (rb_use && decode_rb != 0 && mpend[decode_rb]);
    endfunction

    function automatic bit m_branch();
        bit live = issue_valid && execute_wb && !flush && execute_rd != 0;
        bit hit  = (ra_use && decode_ra == execute_rd) || (rb_use && decode_rb == execute_rd);
        return (branch_decode || jump_decode) && live && hit;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mpend[i] = 1'b0;
        run_len = 0;
        mwdog   = 1'b0;
        mcount  = 0;
    endtask

    task automatic idle();
        decode_ra = '0; decode_rb = '0; ra_use = 0; rb_use = 0;
        branch_decode = 0; jump_decode = 0; issue_valid = 0;
        execute_rd = '0; execute_wb = 0; execute_mem_read = 0;
        wb_valid = 0; wb_rd = '0; flush = 0;
    endtask

    // Called just after a negedge with inputs applied: checks outputs, then
    // advances the model across the next rising edge.
    task automatic cycle();
        bit lu, br, st;
        logic [31:0] cause;
        #1;
        lu = m_load_use();
        br = m_branch();
        st = lu || br;
        cause = lu ? 32'd1 : (br ? 32'd2 : 32'd0);
        check("stall", {31'd0, stall}, {31'd0, st});
        check("cause", {30'd0, stall_cause}, cause);
        check("pending", {16'd0, pending}, mvec());
        check("wdog", {31'd0, wdog_err}, {31'd0, mwdog});
`ifdef CPU_HDU_STATS_EN
        check("stall_count", stall_count, mcount[31:0]);
`endif
        @(posedge clk);
        if (wb_valid) mpend[wb_rd] = 1'b0;
        if (issue_valid && execute_mem_read && execute_wb && !flush && execute_rd != 0)
            mpend[execute_rd] = 1'b1;
        run_len = st ? run_len + 1 : 0;
        if (run_len >= WD) mwdog = 1'b1;
        if (st) mcount++;
        @(negedge clk);
    endtask

    task automatic load(input int rd);
        issue_valid = 1; execute_rd = RW'(rd); execute_wb = 1; execute_mem_read = 1;
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 0;
        // Hazard-shaped inputs during reset must still yield a quiet block.
        load(3); decode_ra = 4'd3; ra_use = 1; branch_decode = 1;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_cause", {30'd0, stall_cause}, 32'd0);
        check("rst_pending", {16'd0, pending}, 32'd0);
        check("rst_wdog", {31'd0, wdog_err}, 32'd0);
        idle();
        rst_n = 1;

        // Load-use on r3, resolved by writeback.
        load(3); cycle();
        idle(); decode_ra = 4'd3; ra_use = 1;
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_cause", {30'd0, stall_cause}, 32'd1);
        cycle();
        wb_valid = 1; wb_rd = 4'd3; cycle();
        wb_valid = 0;
        #1 check("lu_clear_stall", {31'd0, stall}, 32'd0);
        check("lu_clear_pend3", {31'd0, pending[3]}, 32'd0);
        cycle();

        // Load to r0 is never tracked.
        idle(); load(0); cycle();
        idle(); decode_ra = 4'd0; ra_use = 1; decode_rb = 4'd0; rb_use = 1;
        #1 check("r0_stall", {31'd0, stall}, 32'd0);
        check("r0_pending", {16'd0, pending}, 32'd0);
        cycle();

        // Branch operand hazard against an ALU write lasts one cycle.
        idle(); issue_valid = 1; execute_rd = 4'd5; execute_wb = 1;
        branch_decode = 1; decode_rb = 4'd5; rb_use = 1;
        #1 check("br_stall", {31'd0, stall}, 32'd1);
        check("br_cause", {30'd0, stall_cause}, 32'd2);
        cycle();
        issue_valid = 0;
        #1 check("br_bubble_stall", {31'd0, stall}, 32'd0);
        cycle();

        // Flushed load is dropped; simultaneous set and clear keeps the bit.
        idle(); load(4); flush = 1; cycle();
        idle();
        #1 check("flush_pend4", {31'd0, pending[4]}, 32'd0);
        load(4); wb_valid = 1; wb_rd = 4'd4; cycle();
        idle();
        #1 check("setclr_pend4", {31'd0, pending[4]}, 32'd1);
        cycle();

        // Watchdog: 63 stalled edges are fine, the 64th trips it.
        idle(); decode_ra = 4'd4; ra_use = 1;
        for (int i = 0; i < WD - 1; i++) cycle();
        check("wdog_63", {31'd0, wdog_err}, 32'd0);
        cycle();
        check("wdog_64", {31'd0, wdog_err}, 32'd1);
        idle(); wb_valid = 1; wb_rd = 4'd4; cycle();
        idle(); repeat (3) cycle();
        check("wdog_sticky", {31'd0, wdog_err}, 32'd1);

        // Reset asserted mid-stall drops stall immediately and empties the board.
        idle(); load(6); cycle();
        idle(); decode_rb = 4'd6; rb_use = 1;
        #1 check("mid_stall_pre", {31'd0, stall}, 32'd1);
        #1 rst_n = 0;
        #1 check("mid_stall_rst", {31'd0, stall}, 32'd0);
        check("mid_pending_rst", {16'd0, pending}, 32'd0);
        check("mid_wdog_rst", {31'd0, wdog_err}, 32'd0);
`ifdef CPU_HDU_STATS_EN
        check("mid_count_rst", stall_count, 32'd0);
`endif
        @(negedge clk);
        model_reset();
        rst_n = 1;
        cycle();

`ifdef CPU_HDU_STATS_EN
        // Ten held branch-hazard cycles counted, then cleared by reset.
        idle(); issue_valid = 1; execute_rd = 4'd7; execute_wb = 1;
        jump_decode = 1; decode_ra = 4'd7; ra_use = 1;
        repeat (10) cycle();
        check("stats_10", stall_count, 32'd10);
        #1 rst_n = 0;
        #1 check("stats_rst", stall_count, 32'd0);
        check("stats_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        idle();
`endif

        // Randomized traffic over a small register window to make hazards common.
        for (int n = 0; n < 600; n++) begin
            decode_ra        = RW'($urandom_range(0, 3));
            decode_rb        = RW'($urandom_range(0, 3));
            ra_use           = 1'($urandom);
            rb_use           = 1'($urandom);
            branch_decode    = ($urandom_range(0, 3) == 0);
            jump_decode      = ($urandom_range(0, 7) == 0);
            issue_valid      = 1'($urandom);
            execute_rd       = RW'($urandom_range(0, 3));
            execute_wb       = ($urandom_range(0, 3) != 0);
            execute_mem_read = 1'($urandom);
            wb_valid         = ($urandom_range(0, 2) == 0);
            wb_rd            = RW'($urandom_range(0, 3));
            flush            = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
